// File: rtl/multi_ch_sample_queue_if.sv
// Write-strobe / burst-stream bundle for multi_ch_sample_queue.
// QUEUE_MISS_CNT_EN adds the miss_cnt observation signal.
interface multi_ch_sample_queue_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16
);
  logic                     wrt_smpl;
  logic [NUM_CH*DATA_W-1:0] smpl_in;
  logic                     seq_dir;
  logic [NUM_CH*DATA_W-1:0] smpl_out;
  logic                     smpl_valid;
  logic                     sequencing;
  logic                     seq_done;
  logic                     full;
`ifdef QUEUE_MISS_CNT_EN
  logic [7:0]               miss_cnt;

  modport master (output wrt_smpl, smpl_in, seq_dir,
                  input  smpl_out, smpl_valid, sequencing, seq_done, full, miss_cnt);
  modport slave  (input  wrt_smpl, smpl_in, seq_dir,
                  output smpl_out, smpl_valid, sequencing, seq_done, full, miss_cnt);
`else
  modport master (output wrt_smpl, smpl_in, seq_dir,
                  input  smpl_out, smpl_valid, sequencing, seq_done, full);
  modport slave  (input  wrt_smpl, smpl_in, seq_dir,
                  output smpl_out, smpl_valid, sequencing, seq_done, full);
`endif
endinterface

// File: rtl/multi_ch_sample_queue.sv
// Per-channel circular sample RAM; each completed WINDOW history streams out as a burst.
// Define QUEUE_MISS_CNT_EN to count writes that arrive while a burst is running.
module multi_ch_sample_queue #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1536,
  parameter int WINDOW = 1021,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  multi_ch_sample_queue_if.slave bus
);
  localparam int CW = $clog2(WINDOW);
  localparam logic [AW-1:0] LAST_A = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WM1_A  = AW'(WINDOW - 1);
  localparam logic [AW-1:0] WRAP_A = AW'(DEPTH - WINDOW + 1);
  localparam logic [CW-1:0] WM1_C  = CW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, rd_ptr, start_a, next_rd;
  logic [CW-1:0] fill_cnt, cnt_q;
  logic          dir_q, valid_q, seq_q, done_q;
  logic          trig, rd_en, last;

  logic [NUM_CH-1:0][DATA_W-1:0] smpl_d, smpl_q;

  assign smpl_d = bus.smpl_in;
  assign bus.full = (fill_cnt == WM1_C);

  // Forward bursts start at the oldest sample of the window, modulo a non-power-of-two depth.
  assign start_a = bus.seq_dir ? wr_ptr :
                   (wr_ptr >= WM1_A) ? (wr_ptr - WM1_A) : (wr_ptr + WRAP_A);
  assign next_rd = dir_q ? ((rd_ptr == '0) ? LAST_A : rd_ptr - 1'b1)
                         : ((rd_ptr == LAST_A) ? '0 : rd_ptr + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    trig    = 1'b0;
    rd_en   = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.wrt_smpl && bus.full) begin
        trig    = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        rd_en   = 1'b1;
        state_d = READ;
      end
      READ: if (cnt_q == WM1_C) begin
        last    = 1'b1;
        state_d = IDLE;
      end else begin
        rd_en   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      seq_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last;
      if (bus.wrt_smpl) begin
        wr_ptr <= (wr_ptr == LAST_A) ? '0 : wr_ptr + 1'b1;
        if (fill_cnt != WM1_C) fill_cnt <= fill_cnt + 1'b1;
      end
      if (trig) begin
        rd_ptr <= start_a;
        dir_q  <= bus.seq_dir;
        seq_q  <= 1'b1;
      end else if (rd_en) begin
        rd_ptr <= next_rd;
      end
      // cnt_q counts samples already issued; the LOAD read is sample 0.
      if (state_q == LOAD) begin
        cnt_q   <= '0;
        valid_q <= 1'b1;
      end else if (rd_en) begin
        cnt_q   <= cnt_q + 1'b1;
      end
      if (last) begin
        valid_q <= 1'b0;
        seq_q   <= 1'b0;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk) begin
      if (bus.wrt_smpl) mem[wr_ptr] <= smpl_d[ch];
    end

    always_ff @(posedge clk) begin
      if (rst)        q <= '0;
      else if (rd_en) q <= mem[rd_ptr];
    end

    assign smpl_q[ch] = q;
  end

  assign bus.smpl_out   = smpl_q;
  assign bus.smpl_valid = valid_q;
  assign bus.sequencing = seq_q;
  assign bus.seq_done   = done_q;

`ifdef QUEUE_MISS_CNT_EN
  logic [7:0] miss_q;

  always_ff @(posedge clk) begin
    if (rst)                                         miss_q <= '0;
    else if (bus.wrt_smpl && seq_q && miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
  end

  assign bus.miss_cnt = miss_q;
`else
  // default build carries no miss tracking
`endif
endmodule
